// File: rtl/result_unloader_if.sv
// Handshake/RAM bundle between the result unloader (master) and the host plus RAM A (slave).
interface result_unloader_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, ram_dout, out_ready,
        output ram_addr, ram_rd, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, ram_dout, out_ready,
        input  ram_addr, ram_rd, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/result_unloader.sv
// Reads NUM_RESULTS result words from RAM A and streams them out over valid/ready.
// Optional RESULT_UNLOADER_CHECKSUM_EN appends a mod-2^DATA_W sum word after the data.
module result_unloader #(
    parameter int DATA_W      = 10,
    parameter int ADDR_W      = 5,
    parameter int NUM_RESULTS = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic               clk,
    input  logic               res,
    result_unloader_if.master  bus
);
    localparam int IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RESULTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_is_last;

`ifdef RESULT_UNLOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum, w_sum_nxt;

    function automatic logic [DATA_W-1:0] f_wrap_add(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        return a + b;
    endfunction
`endif

    assign w_is_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        w_sum_nxt   = r_sum;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_ISSUE;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                    w_sum_nxt   = '0;
`endif
                end
            end
            S_ISSUE: w_state_nxt = S_CAPTURE;
            // Synchronous RAM: data read in ISSUE is on ram_dout now.
            S_CAPTURE: begin
                w_data_nxt  = bus.ram_dout;
                w_valid_nxt = 1'b1;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                w_last_nxt  = 1'b0;
`else
                w_last_nxt  = w_is_last;
`endif
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_valid_nxt = 1'b0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                    w_sum_nxt   = f_wrap_add(r_sum, r_data);
`endif
                    if (!w_is_last) begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_ISSUE;
                    end else begin
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                        // Sum word is presented directly, no RAM read needed.
                        w_data_nxt  = f_wrap_add(r_sum, r_data);
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = 1'b1;
                        w_state_nxt = S_CKSUM;
`else
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (bus.out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            r_sum   <= w_sum_nxt;
`endif
        end
    end

    // Address wraps modulo 2^ADDR_W by truncation.
    assign bus.ram_addr  = BASE_A + ADDR_W'(r_idx);
    assign bus.ram_rd    = (r_state == S_ISSUE);
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: reset, streaming, backpressure, address wrap, abort, checksum.
module tb_result_unloader;
    logic clk = 1'b0;
    logic res = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    result_unloader_if #(.DATA_W(10), .ADDR_W(5)) bus();
    result_unloader_if #(.DATA_W(10), .ADDR_W(5)) bus2();

    result_unloader #(.DATA_W(10), .ADDR_W(5), .NUM_RESULTS(16), .BASE_ADDR(0)) dut (
        .clk(clk), .res(res), .bus(bus)
    );
    result_unloader #(.DATA_W(10), .ADDR_W(5), .NUM_RESULTS(4), .BASE_ADDR(30)) dut2 (
        .clk(clk), .res(res), .bus(bus2)
    );

    logic [9:0] mem  [32];
    logic [9:0] mem2 [32];
    logic [4:0] addr_q [$];
    logic [9:0] data_q [$];

    // Synchronous-read RAM models.
    always @(posedge clk) if (bus.ram_rd)  bus.ram_dout  <= mem[bus.ram_addr];
    always @(posedge clk) if (bus2.ram_rd) bus2.ram_dout <= mem2[bus2.ram_addr];

    always @(posedge clk) begin
        if (bus2.ram_rd) addr_q.push_back(bus2.ram_addr);
        if (bus2.out_valid && bus2.out_ready) data_q.push_back(bus2.out_data);
    end

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    // Returns negedges waited until out_valid, or -1 if it never came.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.out_ready = 0; bus2.start = 0; bus2.out_ready = 0;
        res = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 10'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", bus.out_data); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.done); end
        total++; if (bus.ram_rd !== 1'b0) begin bad++; $display("FAIL reset_ram_rd got=%b exp=0", bus.ram_rd); end
        total++; if (bus.ram_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.ram_addr); end
        total++; if (bus2.ram_addr !== 5'd30) begin bad++; $display("FAIL reset_addr_base got=%0d exp=30", bus2.ram_addr); end
        @(negedge clk) res = 1'b0;
    endtask

    task automatic test_normal();
        int n;
        logic exp_last;
        bus.out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            wait_valid(n);
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            exp_last = 1'b0;
`else
            exp_last = (k == 15);
`endif
            total++; if (n != ((k == 0) ? 2 : 3)) begin bad++; $display("FAIL normal_spacing word=%0d got=%0d exp=%0d", k, n, (k == 0) ? 2 : 3); end
            total++; if (bus.out_data !== 10'(k + 1)) begin bad++; $display("FAIL normal_data word=%0d got=%h exp=%h", k, bus.out_data, 10'(k + 1)); end
            total++; if (bus.out_last !== exp_last) begin bad++; $display("FAIL normal_last word=%0d got=%b exp=%b", k, bus.out_last, exp_last); end
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL normal_busy word=%0d got=%b exp=1", k, bus.busy); end
        end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        wait_valid(n);
        total++; if (n != 1) begin bad++; $display("FAIL cksum_latency got=%0d exp=1", n); end
        total++; if (bus.out_data !== 10'h088) begin bad++; $display("FAIL cksum_seq got=%h exp=088", bus.out_data); end
        total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL cksum_last got=%b exp=1", bus.out_last); end
`endif
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin bad++; $display("FAIL normal_end busy/done got=%b%b exp=01", bus.busy, bus.done); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL normal_end_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b1;
        pulse_start();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL restart_done_clear busy/done got=%b%b exp=10", bus.busy, bus.done); end
        for (int k = 0; k < 16; k++) begin
            wait_valid(n);
            total++; if (n != ((k == 0) ? 2 : 3) || bus.out_data !== 10'(k + 1)) begin bad++; $display("FAIL bp_word word=%0d got n=%0d data=%h exp n=%0d data=%h", k, n, bus.out_data, (k == 0) ? 2 : 3, 10'(k + 1)); end
            if (k == 3) begin
                bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 10'h004 || bus.ram_rd !== 1'b0) begin bad++; $display("FAIL bp_hold cycle=%0d got valid=%b data=%h rd=%b exp 1 004 0", c, bus.out_valid, bus.out_data, bus.ram_rd); end
                end
                bus.out_ready = 1'b1;
            end
        end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        wait_valid(n);
`endif
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", bus.done); end
    endtask

    task automatic test_wrap();
        addr_q.delete(); data_q.delete();
        bus2.out_ready = 1'b1;
        @(negedge clk) bus2.start = 1'b1;
        @(negedge clk) bus2.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus2.done === 1'b1) break;
            @(negedge clk);
        end
        total++; if (bus2.done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", bus2.done); end
        total++; if (addr_q.size() != 4) begin bad++; $display("FAIL wrap_reads got=%0d exp=4", addr_q.size()); end
        else if (addr_q[0] !== 5'd30 || addr_q[1] !== 5'd31 || addr_q[2] !== 5'd0 || addr_q[3] !== 5'd1) begin
            bad++; $display("FAIL wrap_addr got=%0d,%0d,%0d,%0d exp=30,31,0,1", addr_q[0], addr_q[1], addr_q[2], addr_q[3]);
        end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        total++; if (data_q.size() != 5 || data_q[4] !== 10'h03E) begin bad++; $display("FAIL wrap_cksum size=%0d exp size=5 last=03E", data_q.size()); end
`else
        total++; if (data_q.size() != 4) begin bad++; $display("FAIL wrap_xfers got=%0d exp=4", data_q.size()); end
`endif
        total++; if (data_q.size() < 4) begin bad++; $display("FAIL wrap_data got size=%0d exp>=4", data_q.size()); end
        else if (data_q[0] !== 10'h21E || data_q[1] !== 10'h21F || data_q[2] !== 10'h200 || data_q[3] !== 10'h201) begin
            bad++; $display("FAIL wrap_data got=%h,%h,%h,%h exp=21e,21f,200,201", data_q[0], data_q[1], data_q[2], data_q[3]);
        end
    endtask

    task automatic test_ignored_start_and_abort();
        int n;
        int stray;
        bus.out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            wait_valid(n);
            total++; if (n != ((k == 0) ? 2 : 3) || bus.out_data !== 10'(k + 1)) begin bad++; $display("FAIL ign_word word=%0d got n=%0d data=%h exp n=%0d data=%h", k, n, bus.out_data, (k == 0) ? 2 : 3, 10'(k + 1)); end
            if (k == 1) bus.start = 1'b1;
            if (k == 3) bus.start = 1'b0;
        end
        bus.out_ready = 1'b0;
        #2 res = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 10'h000 || bus.out_last !== 1'b0) begin bad++; $display("FAIL abort_out got valid=%b data=%h last=%b exp 0 000 0", bus.out_valid, bus.out_data, bus.out_last); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_rd !== 1'b0 || bus.ram_addr !== 5'd0) begin bad++; $display("FAIL abort_ctl got busy=%b done=%b rd=%b addr=%0d exp 0 0 0 0", bus.busy, bus.done, bus.ram_rd, bus.ram_addr); end
        @(negedge clk) res = 1'b0;
        bus.out_ready = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL abort_quiet got=%0d active cycles exp=0", stray); end
        pulse_start();
        wait_valid(n);
        total++; if (n != 2 || bus.out_data !== 10'h001) begin bad++; $display("FAIL abort_restart got n=%0d data=%h exp n=2 data=001", n, bus.out_data); end
        @(negedge clk) res = 1'b1;
        @(negedge clk) res = 1'b0;
    endtask

`ifdef RESULT_UNLOADER_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 10'h3FF;
        bus.out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            wait_valid(n);
            total++; if (bus.out_data !== 10'h3FF) begin bad++; $display("FAIL ck_data word=%0d got=%h exp=3ff", k, bus.out_data); end
        end
        wait_valid(n);
        total++; if (bus.out_data !== 10'h3F0 || bus.out_last !== 1'b1) begin bad++; $display("FAIL ck_sum got=%h last=%b exp=3f0 last=1", bus.out_data, bus.out_last); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]  = (i < 16) ? 10'(i + 1) : 10'h000;
            mem2[i] = 10'h200 | 10'(i);
        end
        test_reset();
        test_normal();
        test_backpressure();
        test_wrap();
        test_ignored_start_and_abort();
`ifdef RESULT_UNLOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Read-side counterpart to the operand loader: after the systolic array finishes, it reads the result words back out of the result RAM (RAM A).
- Streams the words out over a valid/ready handshake, one word per transfer, with a last-word flag.
- Sits between RAM A's read port and the host/test harness; started by the array's finished flag.

Parameters:
- DATA_W, 10, width of one result word (matches the array's packed result lanes).
- ADDR_W, 5, RAM address width.
- NUM_RESULTS, 16, number of words streamed per run (must be >= 1).
- BASE_ADDR, 0, RAM address of the first result word.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- res  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run when not busy.
- ram_addr  out  ADDR_W  read address to RAM A.
- ram_rd  out  1  read strobe; high for one cycle per word.
- ram_dout  in  DATA_W  RAM read data, valid 1 cycle after the ram_rd cycle (synchronous read).
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- out_last  out  1  high with out_valid on the final word of a run.
- busy  out  1  high from start acceptance until the final transfer completes.
- done  out  1  high after a completed run; held until the next accepted start or reset.

Behaviour:
- Reset (async, res=1) forces, immediately and regardless of clk:
  - state=IDLE, idx=0, ram_addr=BASE_ADDR.
  - ram_rd=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- Reset mid-run aborts the run; no partial words are produced after res deasserts.
- Word index: idx is a count 0..NUM_RESULTS-1. ram_addr = (BASE_ADDR + idx) mod 2^ADDR_W, so the address wraps silently.
- States:
  - IDLE:
    - start=1 -> ISSUE, idx=0, busy=1, done=0.
    - start=0 -> stay.
  - ISSUE: ram_rd=1 and ram_addr set for exactly one cycle -> CAPTURE.
  - CAPTURE: latch ram_dout into out_data; set out_valid=1; set out_last=1 iff idx==NUM_RESULTS-1 -> SEND.
  - SEND: hold out_data, out_valid and out_last stable until out_ready=1. On the transfer edge:
    - not last -> idx+1, out_valid=0, go to ISSUE.
    - last -> out_valid=0, out_last=0, busy=0, done=1, go to DONE.
  - DONE:
    - start=1 -> ISSUE with idx=0 (restart); done clears on that same edge.
    - start=0 -> stay.
- Timing:
  - Minimum spacing is 3 cycles per word (ISSUE, CAPTURE, SEND with out_ready already high).
  - First out_valid is asserted 2 cycles after the start edge.
- Handshake rules:
  - out_valid never depends combinationally on out_ready.
  - Once asserted, out_valid does not drop before the transfer completes.
  - out_ready held high while out_valid=0 has no effect.
- Start during ISSUE, CAPTURE or SEND is ignored: no restart, no queuing.
- NUM_RESULTS=1: the single word carries out_last=1.
- Data is passed through unchanged; no width conversion or sign handling.

Optional Feature:
- Macro: RESULT_UNLOADER_CHECKSUM_EN.
- Defined:
  - The module keeps a running sum of all transferred result words, mod 2^DATA_W. The sum clears when a start is accepted.
  - After the NUM_RESULTS-th word transfers, the FSM enters CKSUM instead of DONE, with no RAM read.
  - CKSUM presents the sum with out_valid=1 and out_last=1 until it is accepted, then goes to DONE.
  - In this build, out_last is 0 on data word NUM_RESULTS-1.
  - busy stays high through CKSUM.
- Undefined: no CKSUM state or sum register; behaviour exactly as above.

Test Plan:
- Reset check: RAM A[0..15]=0x001..0x010, res pulse -> all outputs 0, ram_addr=0.
- Normal run: start pulse, out_ready=1 constant -> 16 transfers of 0x001..0x010 in order, spaced 3 cycles apart. out_last=1 only on 0x010, then busy=0, done=1.
- Backpressure: out_ready=0 for 5 cycles on word 3 (value 0x004) -> out_valid and out_data=0x004 held stable for all 5 cycles. No ram_rd in that window; the sequence resumes intact.
- Address wrap: BASE_ADDR=30, NUM_RESULTS=4 -> ram_addr sequence 30, 31, 0, 1.
- Ignored start and reset mid-run: start pulses while busy change nothing. Assert res while word 7 is valid -> outputs return to 0 at once. A new start afterwards streams from word 0.
- Checksum (macro defined): results 0x001..0x010 -> a 17th word 0x088 with out_last=1 follows word 16. With RAM all 0x3FF, the checksum is 0x3F0 (16×0x3FF mod 1024).
